// File: rtl/pred_resolve_ctrl.sv
// pred_resolve_ctrl: in-order checker for static branch/jump predictions.
// Predicted next PCs are queued at fetch and compared against execute's
// resolved targets. A mismatch produces a one-cycle redirect followed by a
// squash window of FLUSH_CYCLES total cycles.
// Optional macro PRED_RESOLVE_STATS_EN adds saturating resolve/mispredict
// counters (stat_resolved, stat_mispred).
module pred_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid,
  input  logic [31:0]               fetch_pred,
  output logic                      fetch_ready,
  input  logic                      resolve_valid,
  input  logic [31:0]               resolve_target,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic                      flush,
  output logic [$clog2(DEPTH):0]    inflight,
  output logic                      underflow
`ifdef PRED_RESOLVE_STATS_EN
  ,
  output logic [15:0]               stat_resolved,
  output logic [15:0]               stat_mispred
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REDIRECT,
    ST_DRAIN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [FW-1:0]   drain_cnt;
  logic [FW-1:0]   drain_cnt_next;

  logic [31:0]     pred_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic            push;
  logic            pop;
  logic            mispredict;
  logic            push_en;

  // Handshake and event decode; only RUN accepts fetch or resolve traffic
  always_comb begin
    fetch_ready    = (state == ST_RUN) && (inflight < CW'(DEPTH));
    push           = fetch_valid && fetch_ready;
    pop            = (state == ST_RUN) && resolve_valid && (inflight != '0);
    mispredict     = pop && (pred_mem[head] != resolve_target);
    push_en        = push && !mispredict;
    redirect_valid = (state == ST_REDIRECT);
    flush          = (state != ST_RUN);
  end

  // State and squash-window counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Next-state logic: RUN -> REDIRECT on mispredict, then DRAIN until the window closes
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      ST_RUN: begin
        if (mispredict) state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        drain_cnt_next = FW'(FLUSH_CYCLES - 1);
        state_next     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_cnt_next = drain_cnt - FW'(1);
        if (drain_cnt <= FW'(1)) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Prediction storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_en) pred_mem[tail] <= fetch_pred;
  end

  // Queue pointers and occupancy; a mispredict discards everything, including a same-cycle push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
    end else if (mispredict) begin
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
    end else begin
      if (push_en) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
      case ({push_en, pop})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Redirect target capture and sticky underflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc <= '0;
      underflow   <= 1'b0;
    end else begin
      if (mispredict) redirect_pc <= resolve_target;
      if ((state == ST_RUN) && resolve_valid && (inflight == '0)) underflow <= 1'b1;
    end
  end

`ifdef PRED_RESOLVE_STATS_EN
  // Saturating counters of accepted resolves and mispredicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && (stat_resolved != 16'hFFFF))       stat_resolved <= stat_resolved + 16'd1;
      if (mispredict && (stat_mispred != 16'hFFFF)) stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pred_resolve_ctrl.sv
// tb_pred_resolve_ctrl: directed scoreboard bench for pred_resolve_ctrl.
// Expected redirect targets are queued when a mispredicting resolve is
// issued; a negedge monitor pops and compares whenever redirect_valid is up.
module tb_pred_resolve_ctrl;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   fetch_valid;
  logic [31:0]            fetch_pred;
  logic                   fetch_ready;
  logic                   resolve_valid;
  logic [31:0]            resolve_target;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   flush;
  logic [$clog2(DEPTH):0] inflight;
  logic                   underflow;
`ifdef PRED_RESOLVE_STATS_EN
  logic [15:0]            stat_resolved;
  logic [15:0]            stat_mispred;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_redirect_q [$];
  logic [31:0] model_q [$];
  logic [31:0] mon_exp;
  logic [31:0] head_val;
  logic [31:0] new_val;

  pred_resolve_ctrl #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid(fetch_valid),
    .fetch_pred(fetch_pred),
    .fetch_ready(fetch_ready),
    .resolve_valid(resolve_valid),
    .resolve_target(resolve_target),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .inflight(inflight),
    .underflow(underflow)
`ifdef PRED_RESOLVE_STATS_EN
    ,
    .stat_resolved(stat_resolved),
    .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs from a negedge, return at the following negedge
  task automatic apply_stimulus(input logic fv, input logic [31:0] fp, input logic rv, input logic [31:0] rt);
    fetch_valid    = fv;
    fetch_pred     = fp;
    resolve_valid  = rv;
    resolve_target = rt;
    @(posedge clk);
    @(negedge clk);
    fetch_valid    = 1'b0;
    fetch_pred     = '0;
    resolve_valid  = 1'b0;
    resolve_target = '0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fetch_valid    = 1'b0;
    fetch_pred     = '0;
    resolve_valid  = 1'b0;
    resolve_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Redirect monitor: every redirect pulse must match the oldest expected target
  always @(negedge clk) begin
    if (!reset && (redirect_valid === 1'b1)) begin
      if (exp_redirect_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_redirect: got redirect_pc 0x%08h with no redirect expected", redirect_pc);
      end else begin
        mon_exp = exp_redirect_q.pop_front();
        check_output("redirect_pc", redirect_pc, mon_exp);
      end
    end
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    do_reset();

    // Reset state
    check_output("rst_inflight", 32'(inflight), 32'd0);
    check_output("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check_output("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check_output("rst_redirect_pc", redirect_pc, 32'd0);
    check_output("rst_flush", 32'(flush), 32'd0);
    check_output("rst_underflow", 32'(underflow), 32'd0);

    // Correct predictions
    apply_stimulus(1'b1, 32'h0040_0010, 1'b0, '0);
    apply_stimulus(1'b1, 32'h0040_0100, 1'b0, '0);
    check_output("ok_inflight2", 32'(inflight), 32'd2);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0040_0010);
    check_output("ok_inflight1", 32'(inflight), 32'd1);
    check_output("ok_flush1", 32'(flush), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0040_0100);
    check_output("ok_inflight0", 32'(inflight), 32'd0);
    check_output("ok_flush0", 32'(flush), 32'd0);

    // Mispredict with a two-cycle squash window
    apply_stimulus(1'b1, 32'h0040_0020, 1'b0, '0);
    exp_redirect_q.push_back(32'h0040_0008);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0040_0008);
    check_output("mp_redirect_valid", 32'(redirect_valid), 32'd1);
    check_output("mp_flush_redirect", 32'(flush), 32'd1);
    check_output("mp_inflight", 32'(inflight), 32'd0);
    check_output("mp_fetch_ready_redirect", 32'(fetch_ready), 32'd0);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("mp_drain_redirect_valid", 32'(redirect_valid), 32'd0);
    check_output("mp_drain_flush", 32'(flush), 32'd1);
    check_output("mp_drain_pc_held", redirect_pc, 32'h0040_0008);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("mp_run_flush", 32'(flush), 32'd0);
    check_output("mp_run_fetch_ready", 32'(fetch_ready), 32'd1);
    check_output("mp_run_inflight", 32'(inflight), 32'd0);

    // Fill to capacity, then try an extra enqueue
    for (int i = 0; i < DEPTH; i++) begin
      new_val = 32'h0000_1000 + 32'(4 * i);
      model_q.push_back(new_val);
      apply_stimulus(1'b1, new_val, 1'b0, '0);
    end
    check_output("full_inflight", 32'(inflight), 32'd4);
    check_output("full_fetch_ready", 32'(fetch_ready), 32'd0);
    apply_stimulus(1'b1, 32'h0000_2000, 1'b0, '0);
    check_output("full_drop_inflight", 32'(inflight), 32'd4);

    // Drain one slot, then paired push/pop across pointer wrap
    head_val = model_q.pop_front();
    apply_stimulus(1'b0, '0, 1'b1, head_val);
    check_output("wrap_inflight3", 32'(inflight), 32'd3);
    for (int i = 0; i < 6; i++) begin
      new_val  = 32'h0000_3000 + 32'(4 * i);
      head_val = model_q.pop_front();
      model_q.push_back(new_val);
      apply_stimulus(1'b1, new_val, 1'b1, head_val);
      check_output("wrap_pair_inflight", 32'(inflight), 32'd3);
      check_output("wrap_pair_flush", 32'(flush), 32'd0);
    end
    head_val = model_q.pop_front();
    check_output("wrap_model_head", head_val, 32'h0000_300C);
    apply_stimulus(1'b0, '0, 1'b1, head_val);
    check_output("wrap_tail_inflight", 32'(inflight), 32'd2);

    // Simultaneous enqueue with mismatching resolve
    exp_redirect_q.push_back(32'h0040_0040);
    apply_stimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0040_0040);
    model_q.delete();
    check_output("sim_inflight", 32'(inflight), 32'd0);
    check_output("sim_flush", 32'(flush), 32'd1);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("sim_drain_flush", 32'(flush), 32'd1);
    apply_stimulus(1'b1, 32'h0000_5554, 1'b1, 32'h0000_5555);
    check_output("sim_after_drain_inflight", 32'(inflight), 32'd0);
    check_output("sim_after_drain_underflow", 32'(underflow), 32'd0);
    check_output("sim_after_drain_flush", 32'(flush), 32'd0);
    apply_stimulus(1'b1, 32'h0000_0200, 1'b0, '0);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0200);
    check_output("sim_clean_inflight", 32'(inflight), 32'd0);
    check_output("sim_clean_flush", 32'(flush), 32'd0);

    // Underflow is sticky until reset
    apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0300);
    check_output("uf_set", 32'(underflow), 32'd1);
    check_output("uf_flush", 32'(flush), 32'd0);
    apply_stimulus(1'b1, 32'h0000_0300, 1'b0, '0);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0300);
    check_output("uf_held", 32'(underflow), 32'd1);
    do_reset();
    check_output("uf_cleared", 32'(underflow), 32'd0);

`ifdef PRED_RESOLVE_STATS_EN
    // Three matches and one mismatch
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h0000_0010 + 32'(4 * i), 1'b0, '0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0010 + 32'(4 * i));
    exp_redirect_q.push_back(32'h0000_0099);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0099);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("stat_resolved", 32'(stat_resolved), 32'd4);
    check_output("stat_mispred", 32'(stat_mispred), 32'd1);
`endif

    // Reset asserted during REDIRECT takes effect immediately
    apply_stimulus(1'b1, 32'h0000_0700, 1'b0, '0);
    exp_redirect_q.push_back(32'h0000_0704);
    apply_stimulus(1'b0, '0, 1'b1, 32'h0000_0704);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_rst_flush", 32'(flush), 32'd0);
    check_output("async_rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check_output("async_rst_redirect_pc", redirect_pc, 32'd0);
    check_output("async_rst_fetch_ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_output("pending_redirects", 32'(exp_redirect_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pred_resolve_ctrl.md
Name: pred_resolve_ctrl

Overview:
- Tracks in-flight control-flow predictions made by the fetch-stage static predictor. Compares each prediction in order against the outcome resolved in execute.
- On mismatch: issues a one-cycle redirect to fetch, then holds a squash window of programmable length while wrong-path instructions drain.
- Sits between the fetch stage (predictor output) and the execute-stage branch/jump resolution logic.

Parameters:
- DEPTH, 4, max in-flight unresolved control-flow instructions (power of two, >=2)
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (>=1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_valid  input  1  fetch presents a control-flow instruction (j/jal/beq/bne) this cycle
- fetch_pred  input  32  predicted next PC for that instruction
- fetch_ready  output  1  tracker can accept an enqueue this cycle
- resolve_valid  input  1  execute resolves the oldest in-flight control-flow instruction
- resolve_target  input  32  actual next PC of that instruction
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  output  32  corrected fetch PC, valid with redirect_valid
- flush  output  1  squash younger pipeline stages
- inflight  output  $clog2(DEPTH)+1  current queue occupancy
- underflow  output  1  sticky error: resolve with empty queue

Behaviour:
- Reset (async, immediate): state RUN, queue empty, inflight=0, redirect_valid=0, redirect_pc=0, flush=0, underflow=0, fetch_ready=1.
- State machine: RUN, REDIRECT, DRAIN.
- fetch_ready: combinational, = (state==RUN) && (inflight<DEPTH). No same-cycle pop credit.
- Enqueue: fetch_valid && fetch_ready pushes fetch_pred at the tail. fetch_valid with fetch_ready=0 is dropped; fetch must hold it.
- Resolve in RUN with queue non-empty: pop head and compare head against resolve_target (full 32-bit equality).
  - Match: no further action.
  - Mismatch: next cycle state=REDIRECT, redirect_valid=1, redirect_pc=resolve_target, flush=1. Queue cleared, inflight=0.
- Simultaneous enqueue and resolve in RUN:
  - Match: push and pop both take effect; inflight unchanged.
  - Mismatch: the enqueue is discarded, because it is a wrong-path instruction.
- Resolve in RUN with queue empty: ignored; underflow set to 1 and held until reset.
- REDIRECT lasts exactly 1 cycle, then goes to DRAIN.
  - A down-counter loads FLUSH_CYCLES-1. If FLUSH_CYCLES==1, go directly to RUN.
- DRAIN: flush=1, redirect_valid=0; counter decrements each cycle; go to RUN when it reaches 0.
- Total flush high time = FLUSH_CYCLES cycles, starting in the cycle after the mispredicting resolve.
- In REDIRECT/DRAIN, fetch_valid and resolve_valid are ignored; underflow is not set.
- Queue: circular buffer with head/tail pointers of width $clog2(DEPTH); wrap-around modulo DEPTH. inflight is the authoritative full/empty indicator.
- redirect_pc retains its last value when redirect_valid=0.
- Reset mid-redirect/drain returns immediately to the reset state.

Optional Feature:
- Macro: PRED_RESOLVE_STATS_EN.
- Defined: adds outputs stat_resolved[15:0] and stat_mispred[15:0]. Both are 16-bit saturating counters (hold at 16'hFFFF), reset to 0.
  - stat_resolved increments on every accepted resolve (RUN, non-empty).
  - stat_mispred increments on every mismatch.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset check: after reset, expect inflight=0, fetch_ready=1, redirect_valid=0, flush=0, underflow=0.
- Correct predictions: enqueue 0x0040_0010 then 0x0040_0100; resolve with 0x0040_0010 then 0x0040_0100. Expect no redirect, no flush, inflight back to 0.
- Mispredict (FLUSH_CYCLES=2): enqueue 0x0040_0020; resolve with 0x0040_0008. Expect:
  - next cycle: redirect_valid=1, redirect_pc=0x0040_0008, flush=1;
  - following cycle: flush=1 only;
  - then RUN with inflight=0.
- Full and wrap-around (DEPTH=4): enqueue 4 entries. Expect fetch_ready=0 and a 5th fetch_valid ignored. Then do 6 push/pop pairs with matching targets; expect FIFO order preserved across pointer wrap.
- Simultaneous events: 2 entries queued; same cycle, enqueue 0x100 and mismatching resolve. Expect queue cleared and inflight=0, with 0x100 not retained. resolve_valid during DRAIN has no effect.
- Underflow: resolve_valid with an empty queue sets underflow=1, which persists until reset. With PRED_RESOLVE_STATS_EN: after 3 matches and 1 mismatch, expect stat_resolved=4, stat_mispred=1.
